// File: rtl/mem_stage_pkg.sv
// Shared pipeline bus widths, field offsets and bus layouts
// for the execute->mem and mem->writeback boundaries.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 79;
    localparam int MS_TO_WS_BUS_WD = 73;

    // es_to_ms bus field offsets
    localparam int ES_PC_LSB       = 0;
    localparam int ES_ALU_LSB      = 32;
    localparam int ES_DEST_LSB     = 64;
    localparam int ES_GR_WE        = 69;
    localparam int ES_LWR          = 70;
    localparam int ES_LWL          = 71;
    localparam int ES_LHU          = 72;
    localparam int ES_LH           = 73;
    localparam int ES_LBU          = 74;
    localparam int ES_LB           = 75;
    localparam int ES_ADDR_LSB     = 76;
    localparam int ES_RES_FROM_MEM = 78;

    // ms_to_ws bus field offsets
    localparam int MS_PC_LSB       = 0;
    localparam int MS_RESULT_LSB   = 32;
    localparam int MS_DEST_LSB     = 64;
    localparam int MS_WSTRB_LSB    = 69;

    typedef struct packed {
        logic        res_from_mem;
        logic [1:0]  addr_low;
        logic        lb;
        logic        lbu;
        logic        lh;
        logic        lhu;
        logic        lwl;
        logic        lwr;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;

    typedef struct packed {
        logic [3:0]  rf_wstrb;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data extraction and register-file byte strobes
// for byte/half/word and unaligned lwl/lwr loads.
import mem_stage_pkg::*;

module load_align (
    input  logic        i_lb,
    input  logic        i_lbu,
    input  logic        i_lh,
    input  logic        i_lhu,
    input  logic        i_lwl,
    input  logic        i_lwr,
    input  logic        i_gr_we,
    input  logic [1:0]  i_addr_low,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data,
    output logic [3:0]  o_rf_wstrb
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [4:0]  w_lwl_sh;
    logic [4:0]  w_lwr_sh;

    always_comb begin
        w_byte = 8'h00;
        case (i_addr_low)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
            default: w_byte = 8'h00;
        endcase
    end

    assign w_half   = i_addr_low[1] ? i_rdata[31:16] : i_rdata[15:0];
    // lwl shifts left by 3-addr_low bytes, lwr right by addr_low bytes
    assign w_lwl_sh = {~i_addr_low, 3'b000};
    assign w_lwr_sh = {i_addr_low, 3'b000};

    always_comb begin
        o_data = i_rdata;
        unique case (1'b1)
            i_lb:    o_data = {{24{w_byte[7]}}, w_byte};
            i_lbu:   o_data = {24'h000000, w_byte};
            i_lh:    o_data = {{16{w_half[15]}}, w_half};
            i_lhu:   o_data = {16'h0000, w_half};
            i_lwl:   o_data = i_rdata << w_lwl_sh;
            i_lwr:   o_data = i_rdata >> w_lwr_sh;
            default: o_data = i_rdata;
        endcase
    end

    always_comb begin
        o_rf_wstrb = 4'b0000;
        if (i_gr_we) begin
            o_rf_wstrb = 4'b1111;
            if (i_lwl) begin
                case (i_addr_low)
                    2'd0: o_rf_wstrb = 4'b1000;
                    2'd1: o_rf_wstrb = 4'b1100;
                    2'd2: o_rf_wstrb = 4'b1110;
                    default: o_rf_wstrb = 4'b1111;
                endcase
            end else if (i_lwr) begin
                case (i_addr_low)
                    2'd0: o_rf_wstrb = 4'b1111;
                    2'd1: o_rf_wstrb = 4'b0111;
                    2'd2: o_rf_wstrb = 4'b0011;
                    default: o_rf_wstrb = 4'b0001;
                endcase
            end
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: registers the execute payload, aligns
// SRAM load data and holds it across writeback back-pressure.
import mem_stage_pkg::*;

module mem_stage (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic [31:0]                data_sram_rdata,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [3:0]                 ms_fwd_we,
    output logic [4:0]                 ms_fwd_dest,
    output logic [31:0]                ms_fwd_result
);

    es_to_ms_t   r_payload;
    logic        r_valid;
    logic        r_held;
    logic [31:0] r_hold_rdata;

    logic        w_accept;
    logic [31:0] w_rdata;
    logic [31:0] w_load_data;
    logic [3:0]  w_rf_wstrb;
    logic [31:0] w_final_result;
    ms_to_ws_t   w_out;

    assign ms_allowin = !r_valid || ws_allowin;
    assign w_accept   = es_to_ms_valid && ms_allowin;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
        end else if (ms_allowin) begin
            r_valid <= es_to_ms_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_payload <= es_to_ms_t'(es_to_ms_bus);
        end
    end

    // SRAM data is only valid in the first occupied cycle; keep it if stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            r_held       <= 1'b0;
            r_hold_rdata <= 32'h0;
        end else if (w_accept) begin
            r_held       <= 1'b0;
        end else if (r_valid && !r_held && !ws_allowin) begin
            r_held       <= 1'b1;
            r_hold_rdata <= data_sram_rdata;
        end
    end

    assign w_rdata = r_held ? r_hold_rdata : data_sram_rdata;

    load_align u_load_align (
        .i_lb       (r_payload.lb),
        .i_lbu      (r_payload.lbu),
        .i_lh       (r_payload.lh),
        .i_lhu      (r_payload.lhu),
        .i_lwl      (r_payload.lwl),
        .i_lwr      (r_payload.lwr),
        .i_gr_we    (r_payload.gr_we),
        .i_addr_low (r_payload.addr_low),
        .i_rdata    (w_rdata),
        .o_data     (w_load_data),
        .o_rf_wstrb (w_rf_wstrb)
    );

    assign w_final_result = r_payload.res_from_mem ? w_load_data
                                                   : r_payload.alu_result;

    always_comb begin
        w_out.rf_wstrb     = w_rf_wstrb;
        w_out.dest         = r_payload.dest;
        w_out.final_result = w_final_result;
        w_out.pc           = r_payload.pc;
    end

    assign ms_to_ws_valid = r_valid;
    assign ms_to_ws_bus   = w_out;
    assign ms_fwd_we      = r_valid ? w_rf_wstrb : 4'b0000;
    assign ms_fwd_dest    = r_payload.dest;
    assign ms_fwd_result  = w_final_result;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed corner cases plus
// randomized traffic against a per-instruction behavioural model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [78:0] es_to_ms_bus;
    logic [31:0] data_sram_rdata;
    logic        ms_to_ws_valid;
    logic [72:0] ms_to_ws_bus;
    logic [3:0]  ms_fwd_we;
    logic [4:0]  ms_fwd_dest;
    logic [31:0] ms_fwd_result;

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ws_allowin      (ws_allowin),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .data_sram_rdata (data_sram_rdata),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .ms_fwd_we       (ms_fwd_we),
        .ms_fwd_dest     (ms_fwd_dest),
        .ms_fwd_result   (ms_fwd_result)
    );

    always #5 clk = ~clk;

    // op flag groups {lb,lbu,lh,lhu,lwl,lwr,gr_we}
    localparam logic [6:0] OP_LW  = 7'b0000001;
    localparam logic [6:0] OP_LB  = 7'b1000001;
    localparam logic [6:0] OP_LBU = 7'b0100001;
    localparam logic [6:0] OP_LH  = 7'b0010001;
    localparam logic [6:0] OP_LHU = 7'b0001001;
    localparam logic [6:0] OP_LWL = 7'b0000101;
    localparam logic [6:0] OP_LWR = 7'b0000011;

    int n_pass = 0;
    int n_tot  = 0;

    // model: the instruction in the stage and the rdata of its first cycle
    bit          m_known = 0;
    bit          m_valid = 0;
    logic [78:0] m_pay   = '0;
    int          m_age   = 0;
    logic [31:0] m_data  = '0;

    function automatic logic [78:0] mk(input bit rfm, input logic [1:0] a,
                                       input logic [6:0] ops, input logic [4:0] d,
                                       input logic [31:0] alu, input logic [31:0] pc);
        return {rfm, a, ops, d, alu, pc};
    endfunction

    function automatic void ref_ws(input logic [78:0] p, input logic [31:0] rd,
                                   output logic [3:0] strb, output logic [31:0] res);
        int          a;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] ld;
        a  = int'(p[77:76]);
        b  = 8'(rd >> (8 * a));
        h  = 16'(rd >> (16 * (a / 2)));
        ld = rd;
        if (p[75]) ld = 32'($signed(b));
        if (p[74]) ld = {24'h0, b};
        if (p[73]) ld = 32'($signed(h));
        if (p[72]) ld = {16'h0, h};
        if (p[71]) ld = rd << (8 * (3 - a));
        if (p[70]) ld = rd >> (8 * a);
        if (!p[69])     strb = 4'h0;
        else if (p[71]) strb = 4'(4'hF << (3 - a));
        else if (p[70]) strb = 4'(4'hF >> a);
        else            strb = 4'hF;
        res = p[78] ? ld : p[63:32];
    endfunction

    task automatic chk(input string name, input logic [72:0] got, input logic [72:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    endtask

    task automatic model_cmp();
        logic [3:0]  s;
        logic [31:0] r;
        logic [31:0] rd;
        rd = (m_age == 0) ? data_sram_rdata : m_data;
        ref_ws(m_pay, rd, s, r);
        chk("allowin", 73'(ms_allowin), 73'(!m_valid || ws_allowin));
        chk("valid", 73'(ms_to_ws_valid), 73'(m_valid));
        chk("fwd_we", 73'(ms_fwd_we), 73'(m_valid ? s : 4'h0));
        if (m_valid) begin
            chk("bus", ms_to_ws_bus, {s, m_pay[68:64], r, m_pay[31:0]});
            chk("fwd_dest", 73'(ms_fwd_dest), 73'(m_pay[68:64]));
            chk("fwd_result", 73'(ms_fwd_result), 73'(r));
        end
    endtask

    task automatic model_upd();
        if (reset) begin
            m_known = 1;
            m_valid = 0;
        end else begin
            if (m_valid && m_age == 0) m_data = data_sram_rdata;
            if (!m_valid || ws_allowin) begin
                m_valid = es_to_ms_valid;
                if (es_to_ms_valid) begin
                    m_pay = es_to_ms_bus;
                    m_age = 0;
                end
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        if (m_known) model_cmp();
    endtask

    task automatic adv();
        @(posedge clk);
        model_upd();
        #1;
    endtask

    task automatic load(input logic [78:0] bus);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = bus;
        ws_allowin     = 1'b1;
        settle();
        adv();
        es_to_ms_valid = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        ws_allowin      = 1'b1;
        es_to_ms_valid  = 1'b0;
        es_to_ms_bus    = '0;
        data_sram_rdata = '0;
        adv();
        reset = 1'b0;
        settle();
        chk("rst_valid", 73'(ms_to_ws_valid), 73'(0));
        chk("rst_allowin", 73'(ms_allowin), 73'(1));
        chk("rst_fwd_we", 73'(ms_fwd_we), 73'(0));
        adv();

        // lb sign extension from the top byte
        load(mk(1, 2'd3, OP_LB, 5'd3, 32'h1000, 32'hBFC0_0000));
        data_sram_rdata = 32'h8012_3456;
        settle();
        chk("lb_res", 73'(ms_fwd_result), 73'(32'hFFFF_FF80));
        chk("lb_we", 73'(ms_fwd_we), 73'(4'hF));
        adv();

        load(mk(1, 2'd2, OP_LHU, 5'd4, 32'h1002, 32'hBFC0_0004));
        data_sram_rdata = 32'h9ABC_1234;
        settle();
        chk("lhu_res", 73'(ms_fwd_result), 73'(32'h0000_9ABC));
        adv();

        load(mk(1, 2'd1, OP_LWL, 5'd5, 32'h1001, 32'hBFC0_0008));
        data_sram_rdata = 32'h1122_3344;
        settle();
        chk("lwl_res", 73'(ms_fwd_result), 73'(32'h3344_0000));
        chk("lwl_we", 73'(ms_fwd_we), 73'(4'b1100));
        adv();

        load(mk(1, 2'd2, OP_LWR, 5'd6, 32'h1002, 32'hBFC0_000C));
        settle();
        chk("lwr_res", 73'(ms_fwd_result), 73'(32'h0000_1122));
        chk("lwr_we", 73'(ms_fwd_we), 73'(4'b0011));
        adv();

        // stall three cycles while SRAM data moves on
        load(mk(1, 2'd0, OP_LW, 5'd7, 32'h2000, 32'hBFC0_0010));
        data_sram_rdata = 32'h1122_3344;
        ws_allowin = 1'b0;
        settle();
        chk("stall0_res", 73'(ms_fwd_result), 73'(32'h1122_3344));
        adv();
        data_sram_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("stall_res", 73'(ms_fwd_result), 73'(32'h1122_3344));
            chk("stall_allowin", 73'(ms_allowin), 73'(0));
            adv();
        end
        ws_allowin = 1'b1;
        settle();
        chk("release_res", 73'(ms_fwd_result), 73'(32'h1122_3344));
        chk("release_valid", 73'(ms_to_ws_valid), 73'(1));
        adv();
        settle();
        chk("drained", 73'(ms_to_ws_valid), 73'(0));
        adv();

        // back-to-back loads, each on its own live rdata
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(1, 2'd0, OP_LB, 5'd1, 32'h3000, 32'hBFC0_0020);
        settle();
        adv();
        es_to_ms_bus    = mk(1, 2'd2, OP_LH, 5'd2, 32'h3002, 32'hBFC0_0024);
        data_sram_rdata = 32'h0000_00F0;
        settle();
        chk("b2b_a_res", 73'(ms_fwd_result), 73'(32'hFFFF_FFF0));
        chk("b2b_allowin", 73'(ms_allowin), 73'(1));
        adv();
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'h8000_0000;
        settle();
        chk("b2b_b_res", 73'(ms_fwd_result), 73'(32'hFFFF_8000));
        chk("b2b_b_dest", 73'(ms_fwd_dest), 73'(5'd2));
        adv();

        // reset while stalled with data held
        load(mk(1, 2'd0, OP_LW, 5'd9, 32'h4000, 32'hBFC0_0030));
        data_sram_rdata = 32'h0000_0055;
        ws_allowin = 1'b0;
        settle();
        adv();
        data_sram_rdata = 32'h0;
        settle();
        chk("held_res", 73'(ms_fwd_result), 73'(32'h0000_0055));
        reset = 1'b1;
        adv();
        reset = 1'b0;
        settle();
        chk("rst2_valid", 73'(ms_to_ws_valid), 73'(0));
        chk("rst2_allowin", 73'(ms_allowin), 73'(1));
        chk("rst2_fwd_we", 73'(ms_fwd_we), 73'(0));
        adv();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int          k;
            logic [6:0]  ops;
            logic [6:0]  tbl [8];
            tbl = '{7'b0, OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LWL, OP_LWR};
            k   = int'($urandom_range(0, 7));
            ops = tbl[k];
            if (k == 0) ops[0] = 1'($urandom);
            reset           = ($urandom_range(0, 59) == 0);
            ws_allowin      = ($urandom_range(0, 9) < 7);
            es_to_ms_valid  = 1'($urandom);
            es_to_ms_bus    = mk(k != 0, 2'($urandom), ops, 5'($urandom),
                                 $urandom, $urandom);
            data_sram_rdata = $urandom;
            settle();
            adv();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
